hazard_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards and inserts bubbles via the NoOp input of the main decoder.
- Flushes IF/ID on taken beq resolved in ID.
- Runs a req/ack handshake FSM with timeout that freezes the whole pipeline while a data-memory access is outstanding.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_mem_fsm.sv | 63 ++++++
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int STATE_W         = 2;
  localparam int REG_W           = 5;
  localparam int DEF_MEM_TIMEOUT = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  // Wait-counter width able to hold 0..tmo; never narrower than one bit.
  function automatic int wait_cnt_w(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory handshake FSM: state register, MEM_WAIT counter and sticky timeout error.
module hazard_mem_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_start,
  input  logic   i_mem_acc,
  input  logic   i_ack,
  output state_e o_state,
  output logic   o_err
);

  localparam int             WCW = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

  state_e         r_state;
  logic [WCW-1:0] r_wcnt;
  logic           r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // A same-cycle ack is a zero-wait access and never leaves RUN.
          if (i_mem_acc && !i_ack) begin
            r_state <= ST_MEM_WAIT;
            r_wcnt  <= WCW'(1);
          end
        end
        ST_MEM_WAIT: begin
          // A request vanishing mid-wait is treated as completion.
          if (i_ack || !i_mem_acc) begin
            r_state <= ST_RUN;
            r_wcnt  <= '0;
          end else if (r_wcnt == TMO) begin
            r_state <= ST_ERROR;
            r_err   <= 1'b1;
          end else begin
            r_wcnt  <= r_wcnt + WCW'(1);
          end
        end
        default: begin
          r_state <= ST_ERROR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_err   = r_err;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush, memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [REG_W-1:0] ID_rs1_i,
  input  logic [REG_W-1:0] ID_rs2_i,
  input  logic             ID_Branch_i,
  input  logic             ID_eq_i,
  input  logic [REG_W-1:0] EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             MEM_MemRead_i,
  input  logic             MEM_MemWrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             NoOp_o,
  output logic             Flush_o,
  output logic             stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] mem_stall_cnt_o
);

  state_e w_state;
  logic   w_mem_acc, w_lu, w_br, w_active, w_freeze;

  assign w_mem_acc = MEM_MemRead_i | MEM_MemWrite_i;
  // rs2 is compared even for I-type: a spurious bubble is harmless, a missed one is not.
  assign w_lu      = EX_MemRead_i && (EX_rd_i != '0) &&
                     ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));
  assign w_br      = ID_Branch_i & ID_eq_i;
  assign w_active  = (w_state == ST_RUN) || (w_state == ST_MEM_WAIT);
  assign w_freeze  = w_active & w_mem_acc & ~dmem_ack_i;

  hazard_mem_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_start   (start_i),
    .i_mem_acc (w_mem_acc),
    .i_ack     (dmem_ack_i),
    .o_state   (w_state),
    .o_err     (err_o)
  );

  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    NoOp_o      = 1'b0;
    Flush_o     = 1'b0;
    stall_o     = 1'b0;
    dmem_req_o  = w_active & w_mem_acc;
    if (!w_active) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
      stall_o     = 1'b1;
    end else if (w_freeze) begin
      // Freeze keeps the ID instruction intact, so no NoOp here.
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      stall_o     = 1'b1;
    end else if (w_lu) begin
      // A concurrent branch is dropped; it re-resolves next cycle with forwarded data.
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end else if (w_br) begin
      Flush_o     = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             w_lu_bubble;
  logic [CNT_W-1:0] r_lu_cnt, r_flush_cnt, r_mstall_cnt;

  assign w_lu_bubble = w_active & ~w_freeze & w_lu;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lu_cnt     <= '0;
      r_flush_cnt  <= '0;
      r_mstall_cnt <= '0;
    end else begin
      if (w_lu_bubble && (r_lu_cnt != '1))     r_lu_cnt     <= r_lu_cnt + CNT_W'(1);
      if (Flush_o && (r_flush_cnt != '1))      r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
      if (w_freeze && (r_mstall_cnt != '1))    r_mstall_cnt <= r_mstall_cnt + CNT_W'(1);
    end
  end

  assign load_use_cnt_o  = r_lu_cnt;
  assign flush_cnt_o     = r_flush_cnt;
  assign mem_stall_cnt_o = r_mstall_cnt;
`else
  assign load_use_cnt_o  = '0;
  assign flush_cnt_o     = '0;
  assign mem_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {dmem_req, PCWrite, IFIDWrite, NoOp, Flush, stall, err}
  localparam logic [6:0] IDLEV = 7'b0001010;
  localparam logic [6:0] NORM  = 7'b0110000;
  localparam logic [6:0] LUV   = 7'b0001000;
  localparam logic [6:0] BRV   = 7'b0110100;
  localparam logic [6:0] FRZ   = 7'b1000010;
  localparam logic [6:0] ACKV  = 7'b1110000;
  localparam logic [6:0] ERRV  = 7'b0001011;

  logic       clk_i = 1'b0, rst_i = 1'b0, start_i;
  logic [4:0] ID_rs1_i, ID_rs2_i, EX_rd_i;
  logic       ID_Branch_i, ID_eq_i, EX_MemRead_i, MEM_MemRead_i, MEM_MemWrite_i, dmem_ack_i;
  logic       dmem_req_o, PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, stall_o, err_o;
  logic [3:0] load_use_cnt_o, flush_cnt_o, mem_stall_cnt_o;
  logic [6:0] obs;
  logic [6:0] sb[$];
  int         n_chk = 0, n_err = 0;

  assign obs = {dmem_req_o, PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, stall_o, err_o};

  always #5 clk_i = ~clk_i;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i), .ID_Branch_i(ID_Branch_i), .ID_eq_i(ID_eq_i),
    .EX_rd_i(EX_rd_i), .EX_MemRead_i(EX_MemRead_i),
    .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(dmem_req_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .NoOp_o(NoOp_o),
    .Flush_o(Flush_o), .stall_o(stall_o), .err_o(err_o),
    .load_use_cnt_o(load_use_cnt_o), .flush_cnt_o(flush_cnt_o), .mem_stall_cnt_o(mem_stall_cnt_o)
  );

  task automatic clr_inputs();
    start_i = 0; ID_rs1_i = 0; ID_rs2_i = 0; EX_rd_i = 0; ID_Branch_i = 0; ID_eq_i = 0;
    EX_MemRead_i = 0; MEM_MemRead_i = 0; MEM_MemWrite_i = 0; dmem_ack_i = 0;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    clr_inputs();
    #2;
    n_chk++;
    if (obs !== IDLEV || load_use_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || mem_stall_cnt_o !== 4'd0) begin
      n_err++;
      $display("FAIL reset: outs=%b cnt=%0d/%0d/%0d exp outs=%b cnt=0/0/0", obs,
               load_use_cnt_o, flush_cnt_o, mem_stall_cnt_o, IDLEV);
    end
    @(negedge clk_i);
    rst_i = 1;
    sb.push_back(IDLEV);
    #2; e = sb.pop_front(); n_chk++;
    if (obs !== e) begin n_err++; $display("FAIL idle_hold: got %b exp %b", obs, e); end
    @(negedge clk_i);
  endtask

  task automatic test_start();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      clr_inputs();
      start_i = (i == 0);
      sb.push_back(i == 0 ? IDLEV : NORM);
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL start[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_load_use();
    logic [6:0] e;
    for (int i = 0; i < 4; i++) begin
      clr_inputs();
      case (i)
        0: begin EX_MemRead_i = 1; EX_rd_i = 5; ID_rs1_i = 2; ID_rs2_i = 5; end
        1: begin EX_MemRead_i = 1; EX_rd_i = 0; ID_rs1_i = 0; ID_rs2_i = 0; end
        2: begin EX_MemRead_i = 1; EX_rd_i = 9; ID_rs1_i = 9; ID_rs2_i = 3; end
        default: begin EX_rd_i = 9; ID_rs1_i = 9; end
      endcase
      sb.push_back((i == 0 || i == 2) ? LUV : NORM);
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL load_use[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
  endtask

  task automatic test_branch();
    logic [6:0] e;
    for (int i = 0; i < 4; i++) begin
      clr_inputs();
      ID_Branch_i = (i < 3);
      ID_eq_i     = (i != 1);
      if (i == 2) begin EX_MemRead_i = 1; EX_rd_i = 5; ID_rs1_i = 5; end
      sb.push_back(i == 0 ? BRV : (i == 2 ? LUV : NORM));
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL branch[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
    #2; n_chk++;
    if (load_use_cnt_o !== (PERF ? 4'd3 : 4'd0) || flush_cnt_o !== (PERF ? 4'd1 : 4'd0)) begin
      n_err++;
      $display("FAIL hazard_cnt: lu=%0d flush=%0d exp lu=%0d flush=%0d", load_use_cnt_o,
               flush_cnt_o, PERF ? 3 : 0, PERF ? 1 : 0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_mem_wait();
    logic [6:0] e;
    for (int i = 0; i < 5; i++) begin
      clr_inputs();
      MEM_MemRead_i = (i < 4);
      dmem_ack_i    = (i == 3);
      if (i == 0) begin EX_MemRead_i = 1; EX_rd_i = 7; ID_rs1_i = 7; end
      sb.push_back(i < 3 ? FRZ : (i == 3 ? ACKV : NORM));
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL mem_wait[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
    #2; n_chk++;
    if (mem_stall_cnt_o !== (PERF ? 4'd3 : 4'd0) || load_use_cnt_o !== (PERF ? 4'd3 : 4'd0)) begin
      n_err++;
      $display("FAIL mem_stall_cnt: stall=%0d lu=%0d exp stall=%0d lu=%0d", mem_stall_cnt_o,
               load_use_cnt_o, PERF ? 3 : 0, PERF ? 3 : 0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    for (int i = 0; i < 12; i++) begin
      clr_inputs();
      MEM_MemWrite_i = (i < 9);
      MEM_MemRead_i  = (i == 9);
      dmem_ack_i     = (i == 3 || i == 8);
      sb.push_back((i == 3 || i == 8) ? ACKV : (i < 10 ? FRZ : NORM));
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL back_to_back[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
    #2; n_chk++;
    if (mem_stall_cnt_o !== (PERF ? 4'd11 : 4'd0)) begin
      n_err++;
      $display("FAIL b2b_cnt: got %0d exp %0d", mem_stall_cnt_o, PERF ? 11 : 0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_saturate();
    logic [6:0] e;
    for (int i = 0; i < 30; i++) begin
      clr_inputs();
      MEM_MemRead_i = 1;
      dmem_ack_i    = (i % 3 == 2);
      sb.push_back(i % 3 == 2 ? ACKV : FRZ);
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL saturate[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
    clr_inputs();
    #2; n_chk++;
    if (mem_stall_cnt_o !== (PERF ? 4'd15 : 4'd0) || flush_cnt_o !== (PERF ? 4'd1 : 4'd0)) begin
      n_err++;
      $display("FAIL sat_cnt: stall=%0d flush=%0d exp stall=%0d flush=%0d", mem_stall_cnt_o,
               flush_cnt_o, PERF ? 15 : 0, PERF ? 1 : 0);
    end
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    for (int i = 0; i < 8; i++) begin
      clr_inputs();
      MEM_MemRead_i = (i < 6);
      dmem_ack_i    = (i >= 6);
      start_i       = (i == 7);
      sb.push_back(i < 5 ? FRZ : ERRV);
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL timeout[%0d]: got %b exp %b", i, obs, e); end
      @(negedge clk_i);
    end
    clr_inputs();
    #2; rst_i = 0;
    #1; n_chk++;
    if (obs !== IDLEV || mem_stall_cnt_o !== 4'd0 || load_use_cnt_o !== 4'd0) begin
      n_err++;
      $display("FAIL async_rst_err: outs=%b stall=%0d exp outs=%b stall=0", obs, mem_stall_cnt_o, IDLEV);
    end
    @(negedge clk_i);
    rst_i = 1;
  endtask

  task automatic test_reset_mid_access();
    logic [6:0] e;
    for (int i = 0; i < 2; i++) begin
      clr_inputs();
      start_i       = (i == 0);
      MEM_MemRead_i = (i == 1);
      sb.push_back(i == 0 ? IDLEV : FRZ);
      #2; e = sb.pop_front(); n_chk++;
      if (obs !== e) begin n_err++; $display("FAIL mid_access[%0d]: got %b exp %b", i, obs, e); end
      if (i == 0) @(negedge clk_i);
    end
    rst_i = 0;
    #1; n_chk++;
    if (obs !== IDLEV) begin
      n_err++;
      $display("FAIL async_rst_req: got %b exp %b", obs, IDLEV);
    end
    @(negedge clk_i);
    rst_i = 1;
    @(negedge clk_i);
  endtask

  initial begin
    clr_inputs();
    @(negedge clk_i);
    test_reset();
    test_start();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_saturate();
    test_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
